hazard_stall_ctrl: RTL

Central pipeline sequencer for the 5-stage RISC-V CPU.
- Detects load-use and branch-operand hazards in ID.
- Freezes the whole pipeline while the data cache reports a miss.
- Inserts bubbles and flushes IF/ID on taken branches resolved in ID.
- Complements the EX-stage forwarding logic: it stalls only when forwarding cannot cover the dependency, and keeps saturating performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 19 +
 rtl/sat_counter.sv | 39 +++
 rtl/hazard_stall_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hazard_ctrl_pkg;

  // Sequencer states. MEM_WAIT remembers the state it interrupted in resume_q.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BR_LOAD  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  // Default width of the performance counters.
  localparam int CNT_W_DEF = 32;

  // x0 is hard-wired zero, so a write to it never creates a dependency.
  localparam logic [4:0] X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Latency: count visible one cycle after inc_i; holds at all-ones.
// Backpressure: none; inc_i is sampled every cycle.
//
// Ports:
//   clk_i  clock
//   rst_i  asynchronous reset, active-low (clears the count)
//   inc_i  increment request for this cycle
//   cnt_o  current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/bubble/flush sequencer for the 5-stage pipeline.
// Latency: control outputs are combinational from state and inputs (zero cycles).
// Backpressure: MemStall_i freezes the whole pipeline; hazards stall PC and IF/ID only.
//
// Ports:
//   clk_i, rst_i                       clock, async active-low reset
//   IDRs1_i/IDRs2_i, IDUseRs1_i/2_i    source registers of the ID instruction
//   IDBranch_i, IDBranchTaken_i        branch in ID and its comparator result
//   EXRegWrite_i, EXMemRead_i, EXRd_i  destination info of the EX instruction
//   MemStall_i                         data cache busy
//   PCWrite_o, IFIDWrite_o             front-end enables
//   IFIDFlush_o, IDEXBubble_o          squash IF/ID, inject NOP into ID/EX
//   PipeStall_o                        hold ID/EX, EX/MEM, MEM/WB
//   StallCycles_o, FlushCount_o        saturating performance counters
module hazard_stall_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IDRs1_i,
  input  logic [4:0]       IDRs2_i,
  input  logic             IDUseRs1_i,
  input  logic             IDUseRs2_i,
  input  logic             IDBranch_i,
  input  logic             IDBranchTaken_i,
  input  logic             EXRegWrite_i,
  input  logic             EXMemRead_i,
  input  logic [4:0]       EXRd_i,
  input  logic             MemStall_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXBubble_o,
  output logic             PipeStall_o,
  output logic [CNT_W-1:0] StallCycles_o,
  output logic [CNT_W-1:0] FlushCount_o
);

  state_t state_q, state_d;
  state_t resume_q, resume_d;
  state_t eff_state;

  logic hit1, hit2, dep;
  logic load_use, br_alu;

  logic pcw_c, ifidw_c, flush_c, bubble_c, stall_c;

  assign hit1 = IDUseRs1_i && (IDRs1_i == EXRd_i);
  assign hit2 = IDUseRs2_i && (IDRs2_i == EXRd_i);
  assign dep  = (hit1 || hit2) && (EXRd_i != X0);

  // Loads cannot forward into ID or EX in time; ALU results can forward into
  // EX but not into the ID-stage branch comparator.
  assign load_use = EXMemRead_i && dep;
  assign br_alu   = IDBranch_i && EXRegWrite_i && !EXMemRead_i && dep;

  // Once the cache releases, decide as if we were still in the interrupted state.
  assign eff_state = (state_q == ST_MEM_WAIT) ? resume_q : state_q;

  always_comb begin
    pcw_c    = 1'b0;
    ifidw_c  = 1'b0;
    flush_c  = 1'b0;
    bubble_c = 1'b0;
    stall_c  = 1'b0;
    state_d  = state_q;
    resume_d = resume_q;

    if (MemStall_i) begin
      stall_c = 1'b1;
      // Capture only on entry so a pending BR_LOAD bubble survives the miss.
      if (state_q != ST_MEM_WAIT) begin
        resume_d = state_q;
      end
      state_d = ST_MEM_WAIT;
    end else begin
      case (eff_state)
        ST_BR_LOAD: begin
          bubble_c = 1'b1;
          state_d  = ST_RUN;
        end
        default: begin
          if (load_use) begin
            bubble_c = 1'b1;
            // A branch needs the loaded value in ID: one more bubble.
            state_d  = IDBranch_i ? ST_BR_LOAD : ST_RUN;
          end else if (br_alu) begin
            bubble_c = 1'b1;
            state_d  = ST_RUN;
          end else begin
            pcw_c   = 1'b1;
            ifidw_c = 1'b1;
            flush_c = IDBranch_i && IDBranchTaken_i;
            state_d = ST_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_RUN;
      resume_q <= ST_RUN;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
    end
  end

  // Reset overrides everything, including the combinational decode above.
  assign PCWrite_o    = rst_i && pcw_c;
  assign IFIDWrite_o  = rst_i && ifidw_c;
  assign IFIDFlush_o  = rst_i && flush_c;
  assign IDEXBubble_o = rst_i && bubble_c;
  assign PipeStall_o  = rst_i && stall_c;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (rst_i && !PCWrite_o),
    .cnt_o (StallCycles_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (IFIDFlush_o),
    .cnt_o (FlushCount_o)
  );

endmodule
